plic_wb_arbiter: RTL and testbench

PLIC_WB_ARBITER -- requirements
Module: plic_wb_arbiter

---
 rtl/plic_pkg.sv | 12 +
 rtl/rr_picker.sv | 29 ++
 rtl/plic_wb_arbiter.sv | 101 ++++++++++
 tb/tb_plic_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// plic_pkg: shared FSM state encoding and default timeout for the PLIC Wishbone arbiter.
//   IDLE    - port free, round-robin pick among requesters
//   BUSY    - granted master drives the PLIC port
//   RELEASE - one dead cycle with s_stb low before the port is offered again
package plic_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } plic_state_e;
    localparam int PLIC_TIMEOUT = 255;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin one-hot select.
//   req - request vector
//   ptr - index searched first; the search wraps upward from here
//   gnt - one-hot winner (all zero when nothing is requesting)
//   idx - binary index of the winner
//   vld - at least one request present
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!vld && req[(int'(ptr) + i) % N]) begin
                gnt[(int'(ptr) + i) % N] = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/plic_wb_arbiter.sv
// plic_wb_arbiter: round-robin arbiter sharing one PLIC Wishbone register port among masters.
//   clk, reset_n               - rising-edge clock, asynchronous active-low reset
//   m_cyc/m_stb/m_we           - per-master cycle, strobe, write enable
//   m_adr/m_dat_i              - packed per-master address / write data (master k in slice k)
//   m_dat_o/m_ack              - broadcast read data, per-master acknowledge
//   s_cyc/s_stb/s_we/s_adr/s_dat_o - muxed request toward the PLIC (zero unless BUSY)
//   s_dat_i/s_ack              - PLIC read data and acknowledge
//   grant                      - one-hot owner, zero when the port is free
//   timeout_err                - pulses in the cycle a transaction is forced to complete
module plic_wb_arbiter
    import plic_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int PADDR_SIZE  = 30,
    parameter int PDATA_SIZE  = 32,
    parameter int TIMEOUT     = PLIC_TIMEOUT
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_MASTERS-1:0]            m_cyc,
    input  logic [NUM_MASTERS-1:0]            m_stb,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*PADDR_SIZE-1:0] m_adr,
    input  logic [NUM_MASTERS*PDATA_SIZE-1:0] m_dat_i,
    output logic [PDATA_SIZE-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic                              s_cyc,
    output logic                              s_stb,
    output logic                              s_we,
    output logic [PADDR_SIZE-1:0]             s_adr,
    output logic [PDATA_SIZE-1:0]             s_dat_o,
    input  logic [PDATA_SIZE-1:0]             s_dat_i,
    input  logic                              s_ack,
    output logic [NUM_MASTERS-1:0]            grant,
    output logic                              timeout_err
);
    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    plic_state_e            state;
    logic [NUM_MASTERS-1:0] req, pick;
    logic [IW-1:0]          pick_idx, gidx, rr_ptr, nxt_ptr;
    logic                   pick_vld, busy, live, ack_hit, to_hit;
    logic [CW-1:0]          cnt;

    assign req = m_cyc & m_stb;

    rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .req(req),
        .ptr(rr_ptr),
        .gnt(pick),
        .idx(pick_idx),
        .vld(pick_vld)
    );

    // A granted master that drops m_cyc abandons its cycle; nothing is acked then.
    assign busy    = (state == BUSY);
    assign live    = busy && m_cyc[gidx];
    assign ack_hit = live && s_ack;
    // cnt holds the 1-based number of the current BUSY cycle; a real ack wins a tie.
    assign to_hit  = live && !s_ack && (cnt == CW'(TIMEOUT));
    assign nxt_ptr = (gidx == IW'(NUM_MASTERS - 1)) ? '0 : gidx + 1'b1;

    assign s_cyc       = live;
    assign s_stb       = live && m_stb[gidx];
    assign s_we        = live && m_we[gidx];
    assign s_adr       = live ? m_adr[gidx*PADDR_SIZE +: PADDR_SIZE] : '0;
    assign s_dat_o     = live ? m_dat_i[gidx*PDATA_SIZE +: PDATA_SIZE] : '0;
    assign m_ack       = (ack_hit || to_hit) ? grant : '0;
    assign m_dat_o     = ack_hit ? s_dat_i : '0;
    assign timeout_err = to_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            grant  <= '0;
            gidx   <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (pick_vld) begin
                    state <= BUSY;
                    grant <= pick;
                    gidx  <= pick_idx;
                    cnt   <= CW'(1);
                end
                BUSY: begin
                    if (!live || ack_hit || to_hit) state <= RELEASE;
                    if (ack_hit || to_hit) rr_ptr <= nxt_ptr;
                    if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
                end
                RELEASE: begin
                    state <= IDLE;
                    grant <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_plic_wb_arbiter.sv
// tb_plic_wb_arbiter: directed self-checking bench for plic_wb_arbiter (2 masters, TIMEOUT=4).
module tb_plic_wb_arbiter;
    localparam int NM = 2;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam logic [AW-1:0] A0 = 30'h100;
    localparam logic [AW-1:0] A1 = 30'h200;
    localparam logic [DW-1:0] D0 = 32'h1111_0000;
    localparam logic [DW-1:0] D1 = 32'h2222_0000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NM-1:0]    m_cyc, m_stb, m_we, m_ack, grant;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat_i;
    logic [DW-1:0]    m_dat_o, s_dat_o, s_dat_i;
    logic             s_cyc, s_stb, s_we, s_ack, timeout_err;
    logic [AW-1:0]    s_adr;

    int total = 0;
    int bad   = 0;

    plic_wb_arbiter #(
        .NUM_MASTERS(NM), .PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat_i(m_dat_i),
        .m_dat_o(m_dat_o), .m_ack(m_ack),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack(s_ack),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction: requesters in req, expected winner g, slave acks in BUSY cycle n.
    task automatic xact(input string tag, input logic [1:0] req, input logic [1:0] g,
                        input int n, input logic [31:0] d);
        m_cyc |= req;
        m_stb |= req;
        #1;
        chk($sformatf("%s.idle_stb", tag), 64'(s_stb), 64'(0));
        step();
        chk($sformatf("%s.grant", tag), 64'(grant), 64'(g));
        chk($sformatf("%s.stb", tag), 64'(s_stb), 64'(1));
        chk($sformatf("%s.adr", tag), 64'(s_adr), 64'(g[1] ? A1 : A0));
        chk($sformatf("%s.we", tag), 64'(s_we), 64'(g[1]));
        chk($sformatf("%s.wdat", tag), 64'(s_dat_o), 64'(g[1] ? D1 : D0));
        for (int i = 1; i < n; i++) begin
            chk($sformatf("%s.early_ack%0d", tag, i), 64'(m_ack), 64'(0));
            step();
        end
        s_ack = 1'b1;
        s_dat_i = d;
        #1;
        chk($sformatf("%s.ack", tag), 64'(m_ack), 64'(g));
        chk($sformatf("%s.rdat", tag), 64'(m_dat_o), 64'(d));
        chk($sformatf("%s.terr", tag), 64'(timeout_err), 64'(0));
        step();
        s_ack = 1'b0;
        m_cyc &= ~g;
        m_stb &= ~g;
        #1;
        chk($sformatf("%s.rel_stb", tag), 64'(s_stb), 64'(0));
        chk($sformatf("%s.rel_cyc", tag), 64'(s_cyc), 64'(0));
        chk($sformatf("%s.rel_ack", tag), 64'(m_ack), 64'(0));
        step();
        chk($sformatf("%s.idle_grant", tag), 64'(grant), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        m_cyc = '0;
        m_stb = '0;
        m_we = 2'b10;
        m_adr = {A1, A0};
        m_dat_i = {D1, D0};
        s_dat_i = '0;
        s_ack = 1'b0;
        #2;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_ack", 64'(m_ack), 64'(0));
        chk("rst_cyc", 64'(s_cyc), 64'(0));
        chk("rst_stb", 64'(s_stb), 64'(0));
        chk("rst_terr", 64'(timeout_err), 64'(0));
        step();
        step();
        reset_n = 1'b1;

        // stray ack while idle
        s_ack = 1'b1;
        s_dat_i = 32'h77;
        #1;
        chk("stray_ack", 64'(m_ack), 64'(0));
        step();
        chk("stray_ack2", 64'(m_ack), 64'(0));
        chk("stray_grant", 64'(grant), 64'(0));
        s_ack = 1'b0;

        // contention: m0 first, then m1, then m0 again
        xact("c1", 2'b11, 2'b01, 1, 32'hA1);
        xact("c2", 2'b10, 2'b10, 2, 32'hB2);
        xact("c3", 2'b11, 2'b01, 1, 32'hC3);

        // abort: pending m1 drops m_cyc in its 2nd BUSY cycle
        #1;
        chk("ab_idle_stb", 64'(s_stb), 64'(0));
        step();
        chk("ab_grant", 64'(grant), 64'(2'b10));
        step();
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        #1;
        chk("ab_ack", 64'(m_ack), 64'(0));
        chk("ab_cyc", 64'(s_cyc), 64'(0));
        step();
        s_ack = 1'b1;
        #1;
        chk("ab_rel_stb", 64'(s_stb), 64'(0));
        chk("ab_rel_ack", 64'(m_ack), 64'(0));
        s_ack = 1'b0;
        step();
        chk("ab_idle_grant", 64'(grant), 64'(0));
        // pointer still at m1, so m1 wins against m0
        xact("ab_ptr", 2'b11, 2'b10, 1, 32'hE5);

        // single read of 5, acked 3 cycles after s_stb (coincides with TIMEOUT: ack wins)
        xact("read", 2'b01, 2'b01, 4, 32'h5);
        xact("wr", 2'b10, 2'b10, 2, 32'h0);

        // timeout: m0 granted, never acked; m0 keeps requesting
        m_cyc = 2'b11;
        m_stb = 2'b11;
        s_dat_i = 32'hDEAD;
        #1;
        step();
        chk("to_grant", 64'(grant), 64'(2'b01));
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("to_early_ack%0d", i), 64'(m_ack), 64'(0));
            chk($sformatf("to_early_err%0d", i), 64'(timeout_err), 64'(0));
            step();
        end
        chk("to_ack", 64'(m_ack), 64'(2'b01));
        chk("to_err", 64'(timeout_err), 64'(1));
        chk("to_dat", 64'(m_dat_o), 64'(0));
        step();
        chk("to_err_pulse", 64'(timeout_err), 64'(0));
        chk("to_rel_stb", 64'(s_stb), 64'(0));
        step();
        chk("to_idle_grant", 64'(grant), 64'(0));
        xact("to_next", 2'b11, 2'b10, 1, 32'hF6);
        xact("m0", 2'b01, 2'b01, 1, 32'hD4);

        // reset in the middle of an m1 BUSY
        m_cyc = 2'b10;
        m_stb = 2'b10;
        #1;
        step();
        chk("rb_grant", 64'(grant), 64'(2'b10));
        step();
        s_ack = 1'b1;
        s_dat_i = 32'h99;
        reset_n = 1'b0;
        #1;
        chk("rb_grant0", 64'(grant), 64'(0));
        chk("rb_ack", 64'(m_ack), 64'(0));
        chk("rb_cyc", 64'(s_cyc), 64'(0));
        chk("rb_stb", 64'(s_stb), 64'(0));
        chk("rb_we", 64'(s_we), 64'(0));
        chk("rb_adr", 64'(s_adr), 64'(0));
        chk("rb_wdat", 64'(s_dat_o), 64'(0));
        chk("rb_terr", 64'(timeout_err), 64'(0));
        chk("rb_rdat", 64'(m_dat_o), 64'(0));
        s_ack = 1'b0;
        m_cyc = 2'b11;
        m_stb = 2'b11;
        step();
        step();
        reset_n = 1'b1;
        #1;
        chk("rb_idle_grant", 64'(grant), 64'(0));
        step();
        chk("rb_first", 64'(grant), 64'(2'b01));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
